// File: rtl/uart_tx.sv
// UART transmitter: serialises one byte per frame (start, DATA_BITS LSB-first, optional parity, stop).
// Latency: accept -> SYNC, start bit begins on the next baud_tick; each frame bit lasts one tick interval.
// Backpressure: tx_ready is high only in IDLE; tx_valid outside IDLE is ignored and tx_data is not sampled.
//
// Ports:
//   clk        system clock; all state changes on its rising edge
//   reset      synchronous active-high reset, overrides every other input
//   baud_tick  one-clk strobe per bit period from the baud divider
//   tx_data    byte to send; bits above DATA_BITS-1 are ignored
//   tx_valid   tx_data valid; accepted when tx_valid && tx_ready
//   tx_ready   high only in IDLE
//   tx         registered serial line, idles high
//   busy       high whenever a frame is in progress
module uart_tx #(
  parameter int DATA_BITS  = 8,  // 5..8
  parameter int PARITY_EN  = 0,  // 1 = parity bit present
  parameter int PARITY_ODD = 0,  // 1 = odd parity, 0 = even
  parameter int STOP_BITS  = 1   // 1..2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SYNC   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_e;

  localparam logic [2:0] LAST_BIT   = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP  = 1'(STOP_BITS - 1);
  localparam logic       HAS_PARITY = (PARITY_EN != 0);
  localparam logic       ODD_PARITY = (PARITY_ODD != 0);
  // Unused upper bits are cleared at accept so the parity XOR sees only frame bits.
  localparam logic [7:0] DATA_MASK  = 8'((16'd1 << DATA_BITS) - 16'd1);

  state_e     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       stop_cnt_q, stop_cnt_d;
  logic       tx_q, tx_d;

  logic [2:0] nxt_idx;
  logic       parity_bit;

  assign nxt_idx    = bit_cnt_q + 3'd1;
  // XOR gives even parity; inverting it (XNOR) gives odd.
  assign parity_bit = (^data_q) ^ ODD_PARITY;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      data_q     <= 8'd0;
      bit_cnt_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
    end
  end

  // Next-state logic; without baud_tick every busy state holds everything.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        // A tick in the accept cycle is deliberately not used: SYNC waits for
        // the next tick so the start bit is a full tick interval long.
        if (tx_valid && tx_ready) begin
          data_d  = tx_data & DATA_MASK;
          state_d = S_SYNC;
        end
      end
      S_SYNC: begin
        if (baud_tick) begin
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_tick) begin
          tx_d      = data_q[0];
          bit_cnt_d = 3'd0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q != LAST_BIT) begin
            bit_cnt_d = nxt_idx;
            tx_d      = data_q[nxt_idx];
          end else if (HAS_PARITY) begin
            tx_d    = parity_bit;
            state_d = S_PARITY;
          end else begin
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
            state_d    = S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          tx_d = 1'b1;
          if (stop_cnt_q == LAST_STOP) begin
            state_d = S_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    tx_ready = (state_q == S_IDLE);
    busy     = (state_q != S_IDLE);
    tx       = tx_q;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four parameterisations share one stimulus set.
// Instance 0: 8N1, 1: 8E2, 2: 8O1, 3: 5N1. Only the instance under test is checked.
module tb_uart_tx;

  logic       clk;
  logic       reset;
  logic       baud_tick;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [3:0] tx_w;
  logic [3:0] busy_w;
  logic [3:0] rdy_w;

  int n_checks;
  int n_errors;

  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));

  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_8e2 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));

  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));

  uart_tx #(.DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_5n1 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bit interval: 15 quiet clocks then a one-clk tick; returns #1 after the tick edge.
  task automatic bit_tick();
    idle(15);
    baud_tick = 1'b1;
    @(posedge clk);
    #1;
    baud_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  // seq[i] is the line level expected after tick i+1; one more tick must return to IDLE.
  task automatic check_frame(input string tag, input int inst, input int nbits,
                             input logic [15:0] seq);
    logic prev;
    for (int i = 0; i < nbits; i++) begin
      bit_tick();
      chk($sformatf("%s_bit%0d", tag, i), 32'(tx_w[inst]), 32'(seq[i]));
      chk($sformatf("%s_busy%0d", tag, i), 32'(busy_w[inst]), 32'd1);
      prev = tx_w[inst];
      idle(7);
      chk($sformatf("%s_hold%0d", tag, i), 32'(tx_w[inst]), 32'(prev));
      // Re-align: bit_tick adds 15 more, keep the tick interval short but constant.
    end
    bit_tick();
    chk({tag, "_end_busy"}, 32'(busy_w[inst]), 32'd0);
    chk({tag, "_end_rdy"}, 32'(rdy_w[inst]), 32'd1);
    chk({tag, "_end_tx"}, 32'(tx_w[inst]), 32'd1);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    baud_tick = 1'b0;
    tx_data   = 8'h00;
    tx_valid  = 1'b0;
    idle(2);
    reset = 1'b0;

    // Reset state of every instance
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_tx%0d", k), 32'(tx_w[k]), 32'd1);
      chk($sformatf("rst_busy%0d", k), 32'(busy_w[k]), 32'd0);
      chk($sformatf("rst_rdy%0d", k), 32'(rdy_w[k]), 32'd1);
    end

    // Ticks in IDLE do nothing
    bit_tick();
    bit_tick();
    chk("idle_tick_tx", 32'(tx_w[0]), 32'd1);
    chk("idle_tick_busy", 32'(busy_w[0]), 32'd0);

    // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1 then IDLE on tick 11
    do_reset();
    send(8'hA5);
    chk("a5_acc_busy", 32'(busy_w[0]), 32'd1);
    chk("a5_acc_rdy", 32'(rdy_w[0]), 32'd0);
    chk("a5_acc_tx", 32'(tx_w[0]), 32'd1);
    check_frame("a5", 0, 10, 16'b0000_0011_0100_1010);

    // Accept coinciding with baud_tick: line stays high until the following tick
    do_reset();
    tx_data   = 8'hA5;
    tx_valid  = 1'b1;
    baud_tick = 1'b1;
    @(posedge clk);
    #1;
    tx_valid  = 1'b0;
    baud_tick = 1'b0;
    chk("sync_busy", 32'(busy_w[0]), 32'd1);
    chk("sync_tx", 32'(tx_w[0]), 32'd1);
    idle(7);
    chk("sync_hold_tx", 32'(tx_w[0]), 32'd1);
    check_frame("sync_a5", 0, 10, 16'b0000_0011_0100_1010);

    // Back-to-back with tx_valid held: 0x55 then 0x0F; data change mid-frame is ignored
    do_reset();
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_data = 8'h0F;
    check_frame("b2b_55", 0, 10, 16'b0000_0010_1010_1010);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    chk("b2b_acc2_busy", 32'(busy_w[0]), 32'd1);
    chk("b2b_acc2_tx", 32'(tx_w[0]), 32'd1);
    check_frame("b2b_0f", 0, 10, 16'b0000_0010_0001_1110);

    // Reset during data bit 3 aborts; a following 0xFF goes out cleanly
    do_reset();
    send(8'h00);
    repeat (5) bit_tick();
    chk("abort_pre_tx", 32'(tx_w[0]), 32'd0);
    chk("abort_pre_busy", 32'(busy_w[0]), 32'd1);
    do_reset();
    chk("abort_tx", 32'(tx_w[0]), 32'd1);
    chk("abort_busy", 32'(busy_w[0]), 32'd0);
    chk("abort_rdy", 32'(rdy_w[0]), 32'd1);
    bit_tick();
    chk("abort_noresume_tx", 32'(tx_w[0]), 32'd1);
    chk("abort_noresume_busy", 32'(busy_w[0]), 32'd0);
    send(8'hFF);
    check_frame("ff", 0, 10, 16'b0000_0011_1111_1110);

    // 8E2 0x07: parity 1, two stop bits, IDLE on tick 13
    do_reset();
    send(8'h07);
    check_frame("e2_07", 1, 12, 16'b0000_1110_0000_1110);

    // 8O1 0x07: parity 0, IDLE on tick 12
    do_reset();
    send(8'h07);
    check_frame("o1_07", 2, 11, 16'b0000_0100_0000_1110);

    // 5N1 0xFF: five data ones, IDLE on tick 8
    do_reset();
    send(8'hFF);
    check_frame("d5_ff", 3, 7, 16'b0000_0000_0111_1110);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
